// File: rtl/leb128_decoder_if.sv
// ============================================================================
//  Module   : leb128_decoder_if
//  Purpose  : Handshake / result bundle between an instruction fetch unit
//             (master) and the LEB128 immediate decoder (slave).
//  Signals  : start, is_signed, is_64   - decode request and mode
//             byte_in, byte_valid       - byte stream from instruction ROM
//             byte_ready                - decoder accepts byte_in
//             busy, done, value, count  - status and decoded result
//             trap                      - malformed-immediate code
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface leb128_decoder_if;
    logic        start;
    logic        is_signed;
    logic        is_64;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic [63:0] value;
    logic [3:0]  count;
    logic        done;
    logic [2:0]  trap;

    modport master (
        output start, is_signed, is_64, byte_in, byte_valid,
        input  byte_ready, busy, value, count, done, trap
    );

    modport slave (
        input  start, is_signed, is_64, byte_in, byte_valid,
        output byte_ready, busy, value, count, done, trap
    );
endinterface

`default_nettype wire

// File: rtl/leb128_decoder.sv
// ============================================================================
//  Module   : leb128_decoder
//  Purpose  : Decodes one signed/unsigned LEB128 immediate (32- or 64-bit
//             target) from a byte stream, one byte per cycle at most.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous active-high reset
//             bus   - leb128_decoder_if.slave (request, byte stream, result)
//  Params   : TRAP_CODE - code driven on bus.trap for a malformed immediate
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leb128_decoder #(
    parameter logic [2:0] TRAP_CODE = 3'd5
) (
    input  logic               clk,
    input  logic               reset,
    leb128_decoder_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [6:0]  shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic        w64_q, w64_d;
    logic [63:0] value_q, value_d;
    logic [3:0]  count_q, count_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic [2:0]  trap_q, trap_d;

    // Per-byte datapath, evaluated on the byte currently presented.
    logic [63:0] w_shifted;
    logic [63:0] w_acc_new;
    logic [63:0] w_result;
    logic [6:0]  w_shift_after;
    logic [3:0]  w_cnt_after;
    logic        w_is_last;
    logic        w_range_ok;
    logic        w_err;

    always_comb begin
        // Shifting a 64-bit operand drops anything that would land past bit 63.
        w_shifted     = {57'd0, bus.byte_in[6:0]} << shift_q;
        w_acc_new     = acc_q | w_shifted;
        w_shift_after = shift_q + 7'd7;
        w_cnt_after   = cnt_q + 4'd1;
        w_is_last     = (w_cnt_after == (w64_q ? 4'd10 : 4'd5));

        // On the longest legal encoding the payload bits above the target
        // width must be zero (unsigned) or copies of the sign bit (signed).
        if (w64_q) begin
            if (sgn_q)
                w_range_ok = (bus.byte_in[6:0] == 7'h00) || (bus.byte_in[6:0] == 7'h7F);
            else
                w_range_ok = (bus.byte_in[6:1] == 6'd0);
        end else begin
            if (sgn_q)
                w_range_ok = (bus.byte_in[6:3] == 4'h0) || (bus.byte_in[6:3] == 4'hF);
            else
                w_range_ok = (bus.byte_in[6:4] == 3'd0);
        end
        w_err = w_is_last && (bus.byte_in[7] || !w_range_ok);

        w_result = w_acc_new;
        if (sgn_q && bus.byte_in[6] && (w_shift_after < (w64_q ? 7'd64 : 7'd32)))
            w_result = w_result | (~64'd0 << w_shift_after);
        // 32-bit results are always stored zero-extended.
        if (!w64_q)
            w_result = {32'd0, w_result[31:0]};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        w64_d   = w64_q;
        value_d = value_q;
        count_d = count_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        trap_d  = trap_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DECODE;
                    acc_d   = 64'd0;
                    shift_d = 7'd0;
                    cnt_d   = 4'd0;
                    trap_d  = 3'd0;
                    sgn_d   = bus.is_signed;
                    w64_d   = bus.is_64;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            DECODE: begin
                if (bus.byte_valid && ready_q) begin
                    acc_d   = w_acc_new;
                    shift_d = w_shift_after;
                    cnt_d   = w_cnt_after;
                    if (w_err) begin
                        state_d = IDLE;
                        trap_d  = TRAP_CODE;
                        busy_d  = 1'b0;
                        ready_d = 1'b0;
                    end else if (!bus.byte_in[7]) begin
                        state_d = FINISH;
                        value_d = w_result;
                        count_d = w_cnt_after;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b0;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= 64'd0;
            shift_q <= 7'd0;
            cnt_q   <= 4'd0;
            sgn_q   <= 1'b0;
            w64_q   <= 1'b0;
            value_q <= 64'd0;
            count_q <= 4'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            trap_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            w64_q   <= w64_d;
            value_q <= value_d;
            count_q <= count_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            trap_q  <= trap_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.value      = value_q;
    assign bus.count      = count_q;
    assign bus.done       = done_q;
    assign bus.trap       = trap_q;

endmodule

`default_nettype wire

// File: tb/tb_leb128_decoder.sv
// ============================================================================
//  Module   : tb_leb128_decoder
//  Purpose  : Directed self-checking bench for leb128_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leb128_decoder;

    localparam logic [2:0] C_TRAP = 3'd5;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    leb128_decoder_if bus ();

    leb128_decoder #(.TRAP_CODE(C_TRAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic sgn, input logic w64);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.is_64     = w64;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.is_signed  = 1'b0;
        bus.is_64      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_value", bus.value, 64'd0);
        check("rst_count", {60'd0, bus.count}, 64'd0);
        check("rst_flags", {60'd0, bus.done, bus.busy, bus.byte_ready, 1'b0}, 64'd0);
        check("rst_trap",  {61'd0, bus.trap}, 64'd0);
        reset = 1'b0;
        tick();

        // Unsigned 64: E5 8E 26 back-to-back -> 624485
        do_start(1'b0, 1'b1);
        check("u64_busy_ready", {62'd0, bus.busy, bus.byte_ready}, 64'd3);
        send_byte(8'hE5);
        send_byte(8'h8E);
        check("u64_no_early_done", {63'd0, bus.done}, 64'd0);
        send_byte(8'h26);
        check("u64_done",  {63'd0, bus.done}, 64'd1);
        check("u64_value", bus.value, 64'h0000_0000_0009_8765);
        check("u64_count", {60'd0, bus.count}, 64'd3);
        check("u64_busy",  {62'd0, bus.busy, bus.byte_ready}, 64'd0);
        check("u64_trap",  {61'd0, bus.trap}, 64'd0);
        tick();
        check("u64_done_pulse", {63'd0, bus.done}, 64'd0);
        check("u64_value_held", bus.value, 64'h0000_0000_0009_8765);

        // Signed 64: C0, idle cycle, BB 78
        do_start(1'b1, 1'b1);
        send_byte(8'hC0);
        tick();
        check("s64_idle_busy", {62'd0, bus.busy, bus.done}, 64'd2);
        send_byte(8'hBB);
        send_byte(8'h78);
        check("s64_done",  {63'd0, bus.done}, 64'd1);
        check("s64_value", bus.value, 64'hFFFF_FFFF_FFFE_1DC0);
        check("s64_count", {60'd0, bus.count}, 64'd3);
        tick();

        // Signed 32 / unsigned 32 single byte 7F
        do_start(1'b1, 1'b0);
        send_byte(8'h7F);
        check("s32_7f_value", bus.value, 64'h0000_0000_FFFF_FFFF);
        check("s32_7f_count", {60'd0, bus.count}, 64'd1);
        tick();
        do_start(1'b0, 1'b0);
        send_byte(8'h7F);
        check("u32_7f_value", bus.value, 64'h0000_0000_0000_007F);
        tick();

        // Unsigned 32 longest legal encoding: FF FF FF FF 0F -> 0xFFFFFFFF
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        send_byte(8'h0F);
        check("u32_max_value", bus.value, 64'h0000_0000_FFFF_FFFF);
        check("u32_max_count", {60'd0, bus.count}, 64'd5);
        tick();

        // Unsigned 32: 5th byte with payload above bit 31 -> trap
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        send_byte(8'h1F);
        check("u32_range_trap", {61'd0, bus.trap}, {61'd0, C_TRAP});
        check("u32_range_done", {63'd0, bus.done}, 64'd0);
        tick();

        // Unsigned 32: 80 x5 -> continuation on max byte -> trap
        do_start(1'b0, 1'b0);
        check("trap_cleared_on_start", {61'd0, bus.trap}, 64'd0);
        for (int i = 0; i < 5; i++) send_byte(8'h80);
        check("u32_cont_trap",  {61'd0, bus.trap}, {61'd0, C_TRAP});
        check("u32_cont_flags", {61'd0, bus.done, bus.busy, bus.byte_ready}, 64'd0);
        check("u32_cont_value", bus.value, 64'h0000_0000_FFFF_FFFF);
        tick();
        check("u32_cont_ready_after", {62'd0, bus.byte_ready, bus.done}, 64'd0);
        check("u32_cont_trap_held", {61'd0, bus.trap}, {61'd0, C_TRAP});

        // Signed 64: nine 80 then 02 -> trap
        do_start(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(8'h80);
        send_byte(8'h02);
        check("s64_10_trap", {61'd0, bus.trap}, {61'd0, C_TRAP});
        check("s64_10_done", {63'd0, bus.done}, 64'd0);
        tick();

        // Signed 64: nine 80 then 7F -> 0x8000000000000000, count 10;
        // start held through FINISH must be ignored.
        do_start(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(8'h80);
        send_byte(8'h7F);
        check("s64_min_value", bus.value, 64'h8000_0000_0000_0000);
        check("s64_min_count", {60'd0, bus.count}, 64'd10);
        check("s64_min_trap",  {61'd0, bus.trap}, 64'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("finish_start_ignored", {62'd0, bus.busy, bus.byte_ready}, 64'd0);
        tick();
        check("finish_start_idle", {62'd0, bus.busy, bus.byte_ready}, 64'd0);

        // Unsigned 64: nine FF then 01 -> all ones
        do_start(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(8'hFF);
        send_byte(8'h01);
        check("u64_max_value", bus.value, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // Reset mid-decode after E5 8E
        do_start(1'b0, 1'b1);
        send_byte(8'hE5);
        send_byte(8'h8E);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_flags", {61'd0, bus.done, bus.busy, bus.byte_ready}, 64'd0);
        check("midrst_trap",  {61'd0, bus.trap}, 64'd0);
        bus.byte_in    = 8'h26;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        check("midrst_no_done", {62'd0, bus.done, bus.busy}, 64'd0);
        do_start(1'b0, 1'b1);
        send_byte(8'hE5);
        send_byte(8'h8E);
        send_byte(8'h26);
        check("midrst_redo_done",  {63'd0, bus.done}, 64'd1);
        check("midrst_redo_value", bus.value, 64'h0000_0000_0009_8765);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/leb128_decoder.md
LEB128_DECODER -- requirements
Module: leb128_decoder

Interface
REQ-001 Parameter: TRAP_CODE, default 3'd5, trap code driven on trap when an immediate is malformed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin decoding one immediate; sampled only in IDLE.
REQ-005 is_signed  input  1  0 = unsigned LEB128, 1 = signed LEB128; captured with start.
REQ-006 is_64  input  1  0 = 32-bit target, 1 = 64-bit target; captured with start.
REQ-007 byte_in  input  8  next immediate byte from instruction ROM.
REQ-008 byte_valid  input  1  byte_in carries a valid byte this cycle.
REQ-009 byte_ready  output  1  decoder accepts byte_in this cycle.
REQ-010 busy  output  1  high from accepted start until done or error.
REQ-011 value  output  64  decoded immediate; held until next accepted start.
REQ-012 count  output  4  number of bytes consumed by last decode (1..10).
REQ-013 done  output  1  one-cycle pulse: value and count valid.
REQ-014 trap  output  3  0 = none; TRAP_CODE after malformed input, held until next accepted start.

Function
REQ-015 States: IDLE, DECODE, FINISH; error sets trap and returns to IDLE.
REQ-016 IDLE: byte_ready=0, busy=0; start=1 -> DECODE next cycle, clear accumulator, shift, count and trap; latch is_signed and is_64.
REQ-017 start asserted outside IDLE is ignored.
REQ-018 DECODE: byte_ready=1; a byte is accepted only on byte_valid && byte_ready; at most one byte per cycle; without byte_valid, state holds.
REQ-019 Accepted byte: accumulator |= byte_in[6:0] << shift; shift += 7; count += 1; bits shifted beyond bit 63 are discarded.
REQ-020 Max length is 5 bytes (32-bit) or 10 bytes (64-bit); continuation bit set on the max-th byte -> error.
REQ-021 Max-th byte, 32-bit: unsigned requires byte_in[6:4]=0; signed requires byte_in[6:3] all equal; otherwise error.
REQ-022 Max-th byte, 64-bit: unsigned requires byte_in[6:1]=0; signed requires byte_in[6:0] all 0 or all 1; otherwise error.
REQ-023 Error: trap=TRAP_CODE and busy=0 the cycle after the offending byte; done stays 0; value unchanged; state returns to IDLE.
REQ-024 Final byte (bit7=0, legal): signed and shift_after < target width and byte_in[6]=1 -> sign-extend the accumulator from bit shift_after-1 to the target width.
REQ-025 32-bit results: value[63:32]=0 always (i32 stored zero-extended); value[31:0] is the 32-bit result.
REQ-026 FINISH is entered the cycle after the final byte; in it value and count are updated, done=1 for exactly that cycle, busy=0, then IDLE.
REQ-027 Latency: done rises N cycles after the cycle the first byte is accepted, for an N-byte immediate with back-to-back byte_valid.
REQ-028 start in the FINISH cycle is ignored; a new decode may start the cycle after done.

Reset
REQ-029 reset=1 forces IDLE on the next edge regardless of state, including mid-decode.
REQ-030 Reset values: value=0, count=0, done=0, busy=0, byte_ready=0, trap=0; accumulator, shift and latched mode cleared.
REQ-031 A partial decode interrupted by reset produces no done and no trap.

Verification
REQ-032 Unsigned 64, bytes E5 8E 26 back-to-back -> value=0x0000000000098765 (624485), count=3, done one cycle after third byte, trap=0.
REQ-033 Signed 64, bytes C0 BB 78 with one idle cycle (byte_valid=0) between first two -> value=0xFFFFFFFFFFFE1DC0, count=3, done delayed one cycle.
REQ-034 Signed 32, byte 7F -> value=0x00000000FFFFFFFF, count=1; unsigned 32, byte 7F -> value=0x000000000000007F.
REQ-035 Unsigned 32, bytes 80 80 80 80 80 -> trap=TRAP_CODE after fifth byte, no done, byte_ready=0 afterwards.
REQ-036 Signed 64, nine 80 bytes then 02 -> trap=TRAP_CODE; nine 80 bytes then 7F -> value=0x8000000000000000, count=10.
REQ-037 Reset asserted after two of bytes E5 8E 26 accepted -> busy=0, byte_ready=0 next cycle, no done; a fresh decode of E5 8E 26 then yields 624485.
